slv_frame_feeder: RTL
=====================

// Module: slv_frame_feeder
// PURPOSE
//  Transmit side of the accelerator slave-port protocol. It reads a frame of DW-bit image words
//  from a synchronous source RAM and streams them into one arbiter slave port (slv0 or slv1).
//  It drives mode, proc_valid, data and data_valid, and obeys the port's ready.
//  The testbench top instantiates it twice, one per slave port.
// PARAMETERS
//  DW   32  data word width, equal to the slave-port data width
//  AW   10  source RAM word-address width (2^AW words)
// PORTS
//  clk             in   1      clock, all logic on rising edge
//  rst_n           in   1      synchronous active-low reset
//  start           in   1      one-cycle request to send a frame; ignored while busy=1
//  cfg_mode        in   2      processing mode for the frame
//  cfg_proc_val    in   8      processing operand for the frame
//  cfg_base        in   AW     first RAM word address
//  cfg_len         in   AW+1   frame length in words, 0..2^AW
//  mem_rd_en       out  1      RAM read strobe
//  mem_addr        out  AW     RAM read address
//  mem_rd_data     in   DW     RAM data, valid the cycle after mem_rd_en
//  slv_ready       in   1      arbiter accepts a word this cycle
//  slv_mode        out  2      latched cfg_mode
//  slv_proc_valid  out  8      latched cfg_proc_val
//  slv_data        out  DW     current word
//  slv_data_valid  out  1      slv_data holds a word
//  busy            out  1      frame in progress
//  done            out  1      one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): every output is 0 next cycle, including mem_addr and slv_data.
//   The state machine returns to IDLE, the buffer is emptied, and a pending RAM read is dropped.
//   Reset has the same effect in the middle of a frame.
//  FSM states: IDLE, RUN, FIN.
//   IDLE->RUN: start=1 and cfg_len!=0. Latch cfg_*, set busy=1, rd_ptr=0, sent=0.
//   IDLE->FIN: start=1 and cfg_len==0. No reads are issued and data_valid is never raised.
//   RUN->FIN: the transfer of word cfg_len-1 completes.
//   FIN->IDLE: always, after one cycle. done=1 and busy=0 during FIN.
//  slv_mode/slv_proc_valid: loaded at the start edge and held until the next accepted start.
//   They are not cleared at FIN.
//  Transfer: a word moves in any cycle where slv_data_valid=1 and slv_ready=1.
//   While valid=1 and ready=0, slv_data and valid hold stable; valid never drops without a transfer.
//   slv_ready is allowed to toggle on any cycle.
//  Buffer: 2-entry output FIFO; the head drives slv_data.
//   Read issue in RUN: mem_rd_en=1 when rd_ptr<cfg_len and (occupancy + in-flight read) < 2,
//   counting the same-cycle pop. mem_addr = (cfg_base + rd_ptr) mod 2^AW, so addresses wrap past 2^AW-1.
//   rd_ptr increments with each read.
//   The returned word is pushed the cycle after mem_rd_en. A push and a pop in the same cycle are allowed.
//  Timing with start in cycle 0 and ready held 1:
//   mem_rd_en in cycle 1; first valid in cycle 3.
//   One word per cycle after that, so the last transfer is in cycle cfg_len+2.
//   done=1 and busy=0 in cycle cfg_len+3.
//  Counter widths: rd_ptr and sent are AW+1 bits, so cfg_len=2^AW is legal.
// TESTING
//  T1 base=0x010,len=4,RAM[i]=0xA0+i,ready=1 -> mem_rd_en cycles 1-4, data A0..A3 cycles 3-6, done cycle 7
//  T2 same frame, ready=0 cycles 3-5 then 1 -> valid=1, data=0xA0 held cycles 3-5; no read beyond 2 buffered+0 in flight
//  T3 base=0x3FE,len=4 (AW=10) -> mem_addr 0x3FE,0x3FF,0x000,0x001
//  T4 len=0,start=1 -> no mem_rd_en, no valid, done=1 cycle 1, busy never 1
//  T5 start again while busy, cfg_mode changed -> ignored; slv_mode unchanged; frame count unchanged
//  T6 rst_n=0 after 2 of 6 words sent -> next cycle valid=0,busy=0,mem_rd_en=0; new start sends from base cleanly

Source files
------------

// File: rtl/slv_frame_feeder.sv
// Streams a frame of DW-bit words from a synchronous source RAM into one arbiter slave port.
// Reads are issued ahead into a 2-entry output FIFO whose head drives slv_data.
module slv_frame_feeder #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    cfg_mode,
    input  logic [7:0]    cfg_proc_val,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW:0]   cfg_len,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          slv_ready,
    output logic [1:0]    slv_mode,
    output logic [7:0]    slv_proc_valid,
    output logic [DW-1:0] slv_data,
    output logic          slv_data_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_nx;
    logic [AW:0]   len_q, rd_ptr, sent;
    logic [AW-1:0] base_q;
    logic          rd_pend;
    logic [DW-1:0] fifo_q [2];
    logic          wr_sel, rd_sel;
    logic [1:0]    occ;
    logic          start_ok, push, pop, last_pop, room;

    assign start_ok       = start && (state == IDLE);
    assign push           = rd_pend;
    assign slv_data_valid = (occ != 2'd0);
    assign slv_data       = fifo_q[rd_sel];
    assign pop            = slv_data_valid && slv_ready;
    assign last_pop       = pop && (sent == len_q - 1'b1);

    // Buffered plus in-flight words must stay within the two FIFO slots,
    // crediting a pop happening this same cycle.
    assign room      = ({1'b0, occ} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop});
    assign mem_rd_en = (state == RUN) && (rd_ptr < len_q) && room;
    assign mem_addr  = base_q + rd_ptr[AW-1:0];

    assign busy = (state == RUN);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (cfg_len != '0) ? RUN : FIN;
            RUN:     if (last_pop) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slv_mode       <= '0;
            slv_proc_valid <= '0;
            base_q         <= '0;
            len_q          <= '0;
            rd_ptr         <= '0;
            sent           <= '0;
            rd_pend        <= 1'b0;
            wr_sel         <= 1'b0;
            rd_sel         <= 1'b0;
            occ            <= '0;
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
        end else begin
            if (start_ok) begin
                slv_mode       <= cfg_mode;
                slv_proc_valid <= cfg_proc_val;
                base_q         <= cfg_base;
                len_q          <= cfg_len;
                rd_ptr         <= '0;
                sent           <= '0;
            end else begin
                if (mem_rd_en) rd_ptr <= rd_ptr + 1'b1;
                if (pop)       sent   <= sent + 1'b1;
            end
            rd_pend <= mem_rd_en;
            if (push) begin
                fifo_q[wr_sel] <= mem_rd_data;
                wr_sel         <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
